button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//   Consumes the debounced, active-high button level and classifies it into
//   one-cycle event pulses: press, release, long_press and auto-repeat.
//   Sits between the debouncer output and the user logic (counters, menus, displays).
//   Also keeps a wrapping press counter for display and debug.
// PARAMETERS
//   TICK_BITS     21  width of the free-running tick prescaler; tick period = 2**TICK_BITS clocks
//   LONG_TICKS    48  ticks held in PRESSED before long_press fires (>=1)
//   REPEAT_TICKS  10  ticks between repeat pulses once in REPEAT (>=1)
// PORTS
//   clock        in   1  system clock, all logic on posedge
//   reset        in   1  asynchronous, active-high; clears all state
//   btn          in   1  debounced button level, 1 = pressed
//   press        out  1  one-cycle pulse on press
//   release      out  1  one-cycle pulse on release
//   long_press   out  1  one-cycle pulse when hold reaches LONG_TICKS
//   repeat_evt   out  1  one-cycle pulse every REPEAT_TICKS while still held after long_press
//   held         out  1  level, 1 while FSM is not IDLE
//   press_count  out  8  number of press pulses, wraps 255 -> 0
// BEHAVIOUR
//   - Reset: all outputs 0, FSM IDLE, sync flops 0, prescaler 0, hold counter 0.
//   - btn passes through a 2-flop synchronizer, then a 1-flop delay for edge detection:
//     rise = s & ~d, fall = ~s & d.
//   - All outputs are registered. press/release assert 3 clocks after the btn edge is sampled.
//   - Prescaler: TICK_BITS-bit up-counter, free-running, wraps.
//     tick = 1 for one cycle when the counter is all ones. The prescaler is NOT cleared on press.
//   - FSM states: IDLE, PRESSED, REPEAT.
//     IDLE:    rise -> press=1, press_count+1, hold_cnt=0, go PRESSED.
//     PRESSED: fall -> release=1, go IDLE.
//              else on tick: if hold_cnt==LONG_TICKS-1 -> long_press=1, hold_cnt=0, go REPEAT;
//              else hold_cnt+1.
//     REPEAT:  fall -> release=1, go IDLE.
//              else on tick: if hold_cnt==REPEAT_TICKS-1 -> repeat_evt=1, hold_cnt=0;
//              else hold_cnt+1.
//   - Timing: long_press fires on the LONG_TICKS-th tick after press, so the hold time is in
//     ((LONG_TICKS-1)*2**TICK_BITS, LONG_TICKS*2**TICK_BITS] clocks.
//     Repeats are then exactly REPEAT_TICKS*2**TICK_BITS clocks apart.
//   - Simultaneous fall and tick at threshold: release wins; no long_press or repeat_evt that cycle.
//   - At most one of press/release/long_press/repeat_evt is high in any cycle.
//   - hold_cnt width = $clog2(max(LONG_TICKS,REPEAT_TICKS)+1); never exceeds the threshold.
//   - Reset mid-hold: outputs drop immediately (async).
//     If btn is still 1 after reset deasserts, it is seen as a fresh rise:
//     press fires 3 clocks after reset release and press_count becomes 1.
//   - held = (state != IDLE), registered with the state.
// STRUCTURE
//   - Shared header btn_defs.vh: FSM state encodings (IDLE=2'd0, PRESSED=2'd1, REPEAT=2'd2)
//     and the PRESS_CNT_W=8 constant, reused by later button/menu blocks.
//   - One sub-module, tick_prescaler (param TICK_BITS; ports clock, reset, tick).
//     Keep the synchronizer, edge detect and FSM in the top module.
// TESTING  (bench params: TICK_BITS=4, LONG_TICKS=3, REPEAT_TICKS=2; tick every 16 clocks)
//   1. Hold reset 5 clocks with btn=0 -> all outputs 0; press_count=0; no pulses for 100 clocks.
//   2. btn=1 for 20 clocks, then 0 -> press pulse 3 clocks after rise; release pulse 3 clocks
//      after fall; no long_press; held high between them; press_count=1.
//   3. btn=1 for 200 clocks -> exactly one long_press 33..48 clocks after press;
//      then repeat_evt every 32 clocks until fall; then one release.
//   4. Align the fall so the synchronized fall coincides with the 3rd tick -> release=1,
//      long_press never asserted, FSM IDLE.
//   5. Assert reset 40 clocks into a hold with btn kept 1 -> outputs 0 immediately;
//      press fires 3 clocks after reset release; press_count=1.
//   6. 257 short presses (btn 1 for 10 clocks, 0 for 10) -> press_count=1 after wrap;
//      exactly 257 press and 257 release pulses.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// Shared button-block definitions: FSM state encoding and press counter width.
// Reused by later button and menu blocks.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StRepeat  = 2'd2
    } btn_state_e;

    localparam int unsigned PressCntW = 8;

    function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder_tick_prescaler.sv
// Free-running prescaler; tick is high for the one cycle the counter is all ones.
module tick_prescaler #(
    parameter int unsigned TICK_BITS = 21
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [TICK_BITS-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + TICK_BITS'(1);
        end
    end

    assign tick = &count_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/release/long-press/repeat pulses
// and keeps a wrapping press counter.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned TICK_BITS    = 21,
    parameter int unsigned LONG_TICKS   = 48,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 btn,
    output logic                 press,
    output logic                 release_evt,
    output logic                 long_press,
    output logic                 repeat_evt,
    output logic                 held,
    output logic [PressCntW-1:0] press_count
);

    localparam int unsigned HoldW = $clog2(max_ticks(LONG_TICKS, REPEAT_TICKS) + 1);
    localparam logic [HoldW-1:0] LongLast   = HoldW'(LONG_TICKS - 1);
    localparam logic [HoldW-1:0] RepeatLast = HoldW'(REPEAT_TICKS - 1);

    logic                 sync1_q, sync2_q, dly_q;
    logic                 rise, fall, tick;
    btn_state_e           state_q, state_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [PressCntW-1:0] count_d;
    logic                 press_d, release_d, long_d, repeat_d;

    tick_prescaler #(
        .TICK_BITS(TICK_BITS)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign rise = sync2_q & ~dly_q;
    assign fall = ~sync2_q & dly_q;

    // A fall always takes priority over a tick reaching its threshold.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = press_count;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    press_d = 1'b1;
                    count_d = press_count + PressCntW'(1);
                    hold_d  = '0;
                    state_d = StPressed;
                end
            end
            StPressed: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (tick) begin
                    if (hold_q == LongLast) begin
                        long_d  = 1'b1;
                        hold_d  = '0;
                        state_d = StRepeat;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
            end
            StRepeat: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (tick) begin
                    if (hold_q == RepeatLast) begin
                        repeat_d = 1'b1;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            dly_q       <= 1'b0;
            state_q     <= StIdle;
            hold_q      <= '0;
            press_count <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            held        <= 1'b0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            dly_q       <= sync2_q;
            state_q     <= state_d;
            hold_q      <= hold_d;
            press_count <= count_d;
            press       <= press_d;
            release_evt <= release_d;
            long_press  <= long_d;
            repeat_evt  <= repeat_d;
            held        <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios plus random button runs, checked
// cycle by cycle against a tick-counting reference model.
module tb_button_event_decoder;

    localparam int unsigned TickBits    = 4;
    localparam int unsigned LongTicks   = 3;
    localparam int unsigned RepeatTicks = 2;
    localparam int unsigned TickPeriod  = 1 << TickBits;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn   = 1'b0;
    logic       press, release_evt, long_press, repeat_evt, held;
    logic [7:0] press_count;

    button_event_decoder #(
        .TICK_BITS   (TickBits),
        .LONG_TICKS  (LongTicks),
        .REPEAT_TICKS(RepeatTicks)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn        (btn),
        .press      (press),
        .release_evt(release_evt),
        .long_press (long_press),
        .repeat_evt (repeat_evt),
        .held       (held),
        .press_count(press_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: btn samples per edge, edge index since reset, ticks held since press.
    int         k;
    logic       q1, q2, q3;
    logic       m_held;
    int         m_ticks;
    logic [7:0] m_cnt;
    logic       e_press, e_rel, e_long, e_rep;

    int n_press, n_rel, n_long, n_rep;
    int press_k, rel_k, long_k;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; q1 = 0; q2 = 0; q3 = 0;
        m_held = 0; m_ticks = 0; m_cnt = 0;
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
        press_k = -1; rel_k = -1; long_k = -1;
    endtask

    task automatic model_edge(input logic b);
        logic lvl, prv, tk;
        k++;
        lvl = q2;
        prv = q3;
        tk  = ((k - 1) % TickPeriod) == (TickPeriod - 1);
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        if (!m_held) begin
            if (lvl && !prv) begin
                e_press = 1; m_held = 1; m_ticks = 0; m_cnt = m_cnt + 8'd1;
            end
        end else if (!lvl && prv) begin
            e_rel = 1; m_held = 0;
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == LongTicks) e_long = 1;
            else if (m_ticks > LongTicks && ((m_ticks - LongTicks) % RepeatTicks) == 0) e_rep = 1;
        end
        q3 = q2; q2 = q1; q1 = b;
    endtask

    task automatic step(input logic b);
        btn = b;
        @(posedge clock);
        model_edge(b);
        #1;
        check_value("cycle", {press, release_evt, long_press, repeat_evt, held, press_count},
                    {e_press, e_rel, e_long, e_rep, m_held, m_cnt});
        check_value("onehot", ($countones({press, release_evt, long_press, repeat_evt}) <= 1), 1);
        if (press)       begin n_press++; press_k = k; end
        if (release_evt) begin n_rel++;   rel_k   = k; end
        if (long_press)  begin n_long++;  long_k  = k; end
        if (repeat_evt)  n_rep++;
        @(negedge clock);
    endtask

    // Asserts reset asynchronously mid-cycle, holds it n edges, releases on a negedge.
    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        check_value("rst_async", {press, release_evt, long_press, repeat_evt, held, press_count}, 0);
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_value("rst_rel", {press, release_evt, long_press, repeat_evt, held, press_count}, 0);
    endtask

    initial begin
        int len;
        logic lvl;
        model_reset();
        #2;

        // 1: idle after reset
        do_reset(5);
        repeat (100) step(1'b0);
        check_value("s1_pulses", n_press + n_rel + n_long + n_rep, 0);

        // 2: short press
        do_reset(5);
        repeat (20) step(1'b1);
        repeat (6) step(1'b0);
        check_value("s2_press_k", press_k, 3);
        check_value("s2_rel_k", rel_k, 23);
        check_value("s2_long", n_long, 0);
        check_value("s2_count", press_count, 1);

        // 3: long hold with repeats
        do_reset(5);
        repeat (200) step(1'b1);
        repeat (6) step(1'b0);
        check_value("s3_long", n_long, 1);
        check_value("s3_long_dly", (long_k - press_k >= 33) && (long_k - press_k <= 48), 1);
        check_value("s3_rep", n_rep, 4);
        check_value("s3_rel_k", rel_k, 203);
        check_value("s3_rel", n_rel, 1);

        // 4: synchronized fall on the tick that would fire long_press
        do_reset(5);
        repeat (45) step(1'b1);
        repeat (6) step(1'b0);
        check_value("s4_rel_k", rel_k, 48);
        check_value("s4_long", n_long, 0);
        check_value("s4_held", held, 0);

        // 5: reset mid-hold with btn kept high
        do_reset(5);
        repeat (40) step(1'b1);
        check_value("s5_held_pre", held, 1);
        do_reset(3);
        repeat (5) step(1'b1);
        check_value("s5_press_k", press_k, 3);
        check_value("s5_count", press_count, 1);
        repeat (6) step(1'b0);

        // 6: press counter wrap
        do_reset(5);
        for (int i = 0; i < 257; i++) begin
            repeat (10) step(1'b1);
            repeat (10) step(1'b0);
        end
        check_value("s6_press", n_press, 257);
        check_value("s6_rel", n_rel, 257);
        check_value("s6_count", press_count, 1);

        // 7: random runs of high/low levels
        do_reset(5);
        lvl = 1'b0;
        for (int r = 0; r < 60; r++) begin
            lvl = ~lvl;
            len = (($urandom % 4) == 0) ? $urandom_range(60, 140) : $urandom_range(1, 40);
            repeat (len) step(lvl);
        end
        repeat (6) step(1'b0);
        check_value("s7_balance", n_press, n_rel);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
